mult_div_unit: RTL
==================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage of the MIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Arithmetic is iterative at one bit per cycle, and a start/busy/done handshake lets the pipeline controller stall MFHI/MFLO until results are ready. Operand width is parametrised.

## Interface
- WIDTH, 32, operand and HI/LO width; even, ≥ 4.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled on a rising edge while busy = 0.
- op  in  3  operation select:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 110/111 reserved (no-op)
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new values in this cycle.
- div_by_zero  out  1  valid with done; high when a DIV/DIVU had b = 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE
  - RUN (iterations)
  - FIX (sign correction and HI/LO write)
- IDLE, start = 1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - latch a, b, op, and the operand signs;
  - for signed ops, convert operands to magnitudes (unsigned WIDTH bits; the most-negative value maps to 2^(WIDTH-1));
  - clear the iteration counter; go to RUN.
- IDLE, start = 1, op = MTHI/MTLO: hi (or lo) ← a at that edge; done pulses in the following cycle; no busy; state stays IDLE.
- IDLE, start = 1, reserved op: ignored; no done.
- RUN, multiply: shift-add over the 2·WIDTH-bit product, one multiplier bit per cycle. Exactly WIDTH cycles.
- RUN, divide: restoring division, one quotient bit per cycle, using a WIDTH+1-bit partial-remainder subtract. Exactly WIDTH cycles.
- FIX (one cycle), then → IDLE:
  - MULT: negate the 2·WIDTH-bit product if operand signs differ. {hi, lo} ← product.
  - DIV: quotient truncates toward zero. Negate the quotient if signs differ; the remainder takes the dividend's sign. lo ← quotient, hi ← remainder.
  - Most-negative / −1: lo = most-negative, hi = 0 (wraps, no trap).
  - Divide by zero (DIV or DIVU): hi ← a (original), lo ← all ones, div_by_zero = 1. Full latency is still taken.
- start while busy: ignored. Operands are latched, so a/b changes during busy have no effect.
- hi/lo change only at the FIX edge or an MTHI/MTLO edge; they hold otherwise.

## Timing
- Reset (reset_n = 0, asynchronous, any state): state = IDLE; busy, done, div_by_zero, hi, lo, and all internal registers = 0. An in-flight operation is abandoned, with no done pulse and no HI/LO write.
- Edge E0 samples start (arithmetic op): busy = 1 after E0.
- Edges E1…E_WIDTH: iterations.
- Edge E_{WIDTH+1}: FIX writes hi/lo; after it busy = 0 and done = 1 for exactly one cycle.
- Latency from the start edge to hi/lo valid is WIDTH+1 edges (33 for WIDTH = 32). The earliest next start is sampled at the edge that ends the done cycle.
- MTHI/MTLO: hi/lo update at E0; done = 1 in the cycle after E0; div_by_zero = 0.
- div_by_zero is driven only in the done cycle and is 0 otherwise.
- Back-to-back: start held high through done launches the next operation at the edge following the done cycle.

## Test plan
- MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF → done exactly 33 edges after the start edge; hi = 0xFFFFFFFE, lo = 0x00000001; busy high for the preceding 33 cycles.
- MULT a = 0xFFFFFFFD (−3), b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (−21). MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU a = 7, b = 2 → lo = 3, hi = 1. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU a = 5, b = 0 → hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 in the done cycle only.
- MTHI a = 0x12345678, then MTLO a = 0x9ABCDEF0 → hi/lo updated one edge each, done pulses, busy never high. Start MULT, then pulse start with DIVU 10 cycles later → second start ignored; the MULT result is written.
- Start DIV 100/3, drop reset_n at cycle 10 for 2 cycles → hi = lo = 0, busy = 0, no done. Restart DIV 100/3 → lo = 33, hi = 1.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle. MTHI/MTLO write HI/LO directly. A start/busy/done handshake lets
// the pipeline stall MFHI/MFLO until the results are ready.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sign_a;
  logic               neg_res;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   opnd;    // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;     // {upper product, multiplier} or {remainder, dividend/quotient}

  logic               launch;
  logic               move;
  logic               op_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Launch decode, operand magnitudes and the per-cycle datapath step
  always_comb begin
    launch    = (state == S_IDLE) && start && !op[2];
    move      = (state == S_IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
    op_sgn    = !op[0];
    mag_a     = (op_sgn && a[WIDTH-1]) ? -a : a;
    mag_b     = (op_sgn && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift - {1'b0, opnd};
    div_rem   = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    prod_fix  = neg_res ? -acc : acc;
    q_fix     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and busy decode
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (launch) state_nxt = S_RUN;
      S_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration, sign fix-up and HI/LO writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      neg_res     <= 1'b0;
      a_orig      <= '0;
      opnd        <= '0;
      acc         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            is_div  <= op[1];
            sign_a  <= op_sgn & a[WIDTH-1];
            neg_res <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            a_orig  <= a;
            cnt     <= '0;
            if (op[1]) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end else if (move) begin
            if (op[0]) lo <= a;
            else       hi <= a;
            done <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) acc <= {div_rem, acc[WIDTH-2:0], div_ge};
          else        acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div) begin
            if (opnd == '0) begin
              hi          <= a_orig;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
